tick_monitor: RTL and testbench

TICK_MONITOR -- requirements
Module: tick_monitor

---
 rtl/tick_monitor.sv | 128 ++++++++++++
 tb/tb_tick_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/tick_monitor.sv
// Period monitor for a periodic one-cycle tick stream: measures each tick-to-tick
// period, flags early/late ticks, counts errors and reports lock after a run of good periods.
module tick_monitor #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TARGET_FREQ = 2,
  parameter int TOLERANCE   = 16,
  parameter int LOCK_COUNT  = 4,
  localparam int EXPECTED   = CLK_FREQ / TARGET_FREQ,
  localparam int CNT_W      = $clog2(EXPECTED + TOLERANCE + 2)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_early,
  output logic             err_late,
  output logic [7:0]       err_count,
  output logic [CNT_W-1:0] last_period,
  output logic [1:0]       state_dbg
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  MIN_P     = CNT_W'(EXPECTED - TOLERANCE);
  localparam logic [CNT_W-1:0]  TIMEOUT_P = CNT_W'(EXPECTED + TOLERANCE + 1);
  localparam logic [GOOD_W-1:0] LOCK_MAX  = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic               locked_q, locked_d;
  logic               err_early_q, err_early_d;
  logic               err_late_q, err_late_d;
  logic [7:0]         err_count_q, err_count_d;
  logic [CNT_W-1:0]   last_period_q, last_period_d;

  logic [CNT_W-1:0]   p_meas;
  logic               timeout;
  logic [7:0]         err_base;

  // Period including the tick cycle itself; reaching TIMEOUT_P without a tick is a late error.
  assign p_meas  = cnt_q + CNT_W'(1);
  assign timeout = (state_q == MEASURE) && !tick_in && (p_meas == TIMEOUT_P);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      good_q        <= '0;
      locked_q      <= 1'b0;
      err_early_q   <= 1'b0;
      err_late_q    <= 1'b0;
      err_count_q   <= '0;
      last_period_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      good_q        <= good_d;
      locked_q      <= locked_d;
      err_early_q   <= err_early_d;
      err_late_q    <= err_late_d;
      err_count_q   <= err_count_d;
      last_period_q <= last_period_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: if (tick_in) state_d = MEASURE;
        MEASURE: if (timeout) state_d = ACQUIRE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d         = '0;
    good_d        = '0;
    locked_d      = 1'b0;
    err_early_d   = 1'b0;
    err_late_d    = 1'b0;
    last_period_d = last_period_q;
    if (enable && state_q == MEASURE) begin
      good_d   = good_q;
      locked_d = locked_q;
      if (tick_in) begin
        last_period_d = p_meas;
        if (p_meas < MIN_P) begin
          err_early_d = 1'b1;
          good_d      = '0;
          locked_d    = 1'b0;
        end else begin
          good_d = (good_q == LOCK_MAX) ? good_q : good_q + GOOD_W'(1);
          if (good_d == LOCK_MAX) locked_d = 1'b1;
        end
      end else if (timeout) begin
        err_late_d = 1'b1;
        good_d     = '0;
        locked_d   = 1'b0;
      end else begin
        cnt_d = p_meas;
      end
    end
    // A clear in the same cycle as an error still counts that error.
    err_base    = clear_err ? 8'd0 : err_count_q;
    err_count_d = ((err_early_d || err_late_d) && err_base != 8'hFF) ? err_base + 8'd1 : err_base;
  end

  assign locked      = locked_q;
  assign err_early   = err_early_q;
  assign err_late    = err_late_q;
  assign err_count   = err_count_q;
  assign last_period = last_period_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Directed bench for tick_monitor at EXPECTED=10, TOLERANCE=1, LOCK_COUNT=2.
module tb_tick_monitor;

  localparam int CNT_W = $clog2(10 + 1 + 2);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic             enable = 1'b0;
  logic             clear_err = 1'b0;
  logic             locked, err_early, err_late;
  logic [7:0]       err_count;
  logic [CNT_W-1:0] last_period;
  logic [1:0]       state_dbg;

  int n_vec = 0;
  int n_err = 0;

  tick_monitor #(
    .CLK_FREQ(100), .TARGET_FREQ(10), .TOLERANCE(1), .LOCK_COUNT(2)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .tick_in(tick), .enable(enable),
    .clear_err(clear_err), .locked(locked), .err_early(err_early),
    .err_late(err_late), .err_count(err_count), .last_period(last_period),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n cycles after the previous tick, pulse tick for one cycle (optionally with clear_err).
  task automatic tick_after(input int n, input bit clr);
    for (int i = 0; i < n - 1; i++) step();
    tick = 1'b1;
    clear_err = clr;
    step();
    tick = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; tick = 1'b1; clear_err = 1'b1;
    step(); step();
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    n_vec++; if ({locked, err_early, err_late} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {locked, err_early, err_late}); end
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", err_count); end
    n_vec++; if (last_period !== 4'd0) begin n_err++; $display("FAIL reset_last: got %0d want 0", last_period); end
    rst = 1'b0; enable = 1'b0; tick = 1'b0; clear_err = 1'b0;
    step();
  endtask

  task automatic test_steady_lock();
    enable = 1'b1;
    step();
    n_vec++; if (state_dbg !== 2'd1) begin n_err++; $display("FAIL steady_acquire: got %0d want 1", state_dbg); end
    tick_after(3, 1'b0);
    n_vec++; if (state_dbg !== 2'd2) begin n_err++; $display("FAIL steady_measure: got %0d want 2", state_dbg); end
    n_vec++; if (last_period !== 4'd0) begin n_err++; $display("FAIL steady_first_nocheck: got %0d want 0", last_period); end
    tick_after(10, 1'b0);
    n_vec++; if (last_period !== 4'd10) begin n_err++; $display("FAIL steady_p2: got %0d want 10", last_period); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL steady_not_yet: got %0b want 0", locked); end
    tick_after(10, 1'b0);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL steady_locked: got %0b want 1", locked); end
    n_vec++; if (last_period !== 4'd10) begin n_err++; $display("FAIL steady_p3: got %0d want 10", last_period); end
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL steady_count: got %0d want 0", err_count); end
  endtask

  task automatic test_early();
    tick_after(8, 1'b0);
    n_vec++; if (err_early !== 1'b1) begin n_err++; $display("FAIL early_pulse: got %0b want 1", err_early); end
    n_vec++; if (last_period !== 4'd8) begin n_err++; $display("FAIL early_last: got %0d want 8", last_period); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL early_unlock: got %0b want 0", locked); end
    n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL early_count: got %0d want 1", err_count); end
    step();
    n_vec++; if (err_early !== 1'b0) begin n_err++; $display("FAIL early_one_cycle: got %0b want 0", err_early); end
    tick_after(9, 1'b0);
    n_vec++; if (locked !== 1'b0 || last_period !== 4'd10) begin n_err++; $display("FAIL early_relock1: got locked=%0b last=%0d want 0/10", locked, last_period); end
    tick_after(10, 1'b0);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL early_relock2: got %0b want 1", locked); end
  endtask

  task automatic test_timeout();
    int k;
    k = 0;
    while (err_late !== 1'b1 && k < 30) begin step(); k++; end
    n_vec++; if (k != 12) begin n_err++; $display("FAIL timeout_latency: got %0d want 12", k); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL timeout_unlock: got %0b want 0", locked); end
    n_vec++; if (state_dbg !== 2'd1) begin n_err++; $display("FAIL timeout_state: got %0d want 1", state_dbg); end
    n_vec++; if (err_count !== 8'd2) begin n_err++; $display("FAIL timeout_count: got %0d want 2", err_count); end
    step();
    n_vec++; if (err_late !== 1'b0) begin n_err++; $display("FAIL timeout_one_cycle: got %0b want 0", err_late); end
    tick_after(4, 1'b0);
    n_vec++; if (last_period !== 4'd10 || err_early !== 1'b0) begin n_err++; $display("FAIL timeout_nocheck: got last=%0d early=%0b want 10/0", last_period, err_early); end
    n_vec++; if (state_dbg !== 2'd2) begin n_err++; $display("FAIL timeout_remeasure: got %0d want 2", state_dbg); end
  endtask

  task automatic test_tolerance();
    tick_after(9, 1'b0);
    n_vec++; if (err_early !== 1'b0 || last_period !== 4'd9) begin n_err++; $display("FAIL tol_p9: got early=%0b last=%0d want 0/9", err_early, last_period); end
    tick_after(11, 1'b0);
    n_vec++; if (err_early !== 1'b0 || last_period !== 4'd11) begin n_err++; $display("FAIL tol_p11: got early=%0b last=%0d want 0/11", err_early, last_period); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL tol_locked: got %0b want 1", locked); end
    tick_after(8, 1'b0);
    n_vec++; if (err_early !== 1'b1 || locked !== 1'b0) begin n_err++; $display("FAIL tol_p8: got early=%0b locked=%0b want 1/0", err_early, locked); end
    n_vec++; if (err_count !== 8'd3) begin n_err++; $display("FAIL tol_count: got %0d want 3", err_count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) tick_after(2, 1'b0);
    n_vec++; if (err_count !== 8'd255) begin n_err++; $display("FAIL sat_count: got %0d want 255", err_count); end
    tick_after(2, 1'b1);
    n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL sat_clear_with_err: got %0d want 1", err_count); end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL sat_clear_only: got %0d want 0", err_count); end
  endtask

  task automatic test_disable();
    tick_after(3, 1'b0);
    tick_after(10, 1'b0);
    tick_after(10, 1'b0);
    n_vec++; if (locked !== 1'b1 || err_count !== 8'd1) begin n_err++; $display("FAIL dis_setup: got locked=%0b count=%0d want 1/1", locked, err_count); end
    step(); step(); step();
    enable = 1'b0;
    step();
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL dis_state: got %0d want 0", state_dbg); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL dis_locked: got %0b want 0", locked); end
    n_vec++; if (err_count !== 8'd1 || last_period !== 4'd10) begin n_err++; $display("FAIL dis_held: got count=%0d last=%0d want 1/10", err_count, last_period); end
    tick_after(3, 1'b0);
    n_vec++; if (state_dbg !== 2'd0 || err_count !== 8'd1 || last_period !== 4'd10) begin n_err++; $display("FAIL dis_tick_ignored: got state=%0d count=%0d last=%0d want 0/1/10", state_dbg, err_count, last_period); end
  endtask

  task automatic test_reset_mid();
    int late_seen;
    enable = 1'b1;
    step();
    tick_after(2, 1'b0);
    tick_after(10, 1'b0);
    n_vec++; if (state_dbg !== 2'd2 || last_period !== 4'd10) begin n_err++; $display("FAIL rstmid_setup: got state=%0d last=%0d want 2/10", state_dbg, last_period); end
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rstmid_state: got %0d want 0", state_dbg); end
    n_vec++; if ({locked, err_early, err_late} !== 3'b000 || err_count !== 8'd0 || last_period !== 4'd0) begin n_err++; $display("FAIL rstmid_outputs: got flags=%b count=%0d last=%0d want 000/0/0", {locked, err_early, err_late}, err_count, last_period); end
    late_seen = 0;
    for (int i = 0; i < 15; i++) begin step(); if (err_late !== 1'b0) late_seen++; end
    n_vec++; if (late_seen != 0) begin n_err++; $display("FAIL rstmid_no_late: got %0d pulses want 0", late_seen); end
    rst = 1'b0; enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_steady_lock();
    test_early();
    test_timeout();
    test_tolerance();
    test_saturation();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
